// File: rtl/jtag_seq_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_seq_ctrl
//
// Hardware JTAG command sequencer. Accepts one host command at a time
// (TAP reset, TMS sequence, scan, scan with exit on the last bit) and turns
// it into TCK/TMS/TDI waveforms at a programmable TCK rate. TDO is captured
// on the last system clock of each TCK high phase; scan commands return the
// captured bits through a valid/ready response port.
//
// Ports
//   wb_clk_i          system clock, all logic on the rising edge
//   wb_rst_i          synchronous active-high reset
//   cfg_half_period   TCK half period in system clocks minus 1, latched at accept
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op            0=RESET 1=TMS_SEQ 2=SCAN 3=SCAN_FLIP
//   cmd_len           bit count minus 1 (ignored for RESET)
//   cmd_data          TMS bits (TMS_SEQ) or TDI bits (scans), LSB first
//   rsp_valid/ready   scan result handshake
//   rsp_data          captured TDO, bit i = i-th shifted bit, upper bits zero
//   busy              command in progress or response pending
//   jtag_tck/tms/tdi  JTAG pins, registered
//   jtag_tdo          JTAG TDO, already synchronized to wb_clk_i
//
// State table
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | pins idle, cmd_ready high, waiting for a command
//   SHIFT_LO  | TCK low, TMS/TDI presented for bit idx, H cycles
//   SHIFT_HI  | TCK high, H cycles, TDO sampled on the last one
//   RESP      | scan result held on rsp_data until rsp_ready
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module jtag_seq_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [DIV_W-1:0] cfg_half_period,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_len,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             busy,
  output logic             jtag_tck,
  output logic             jtag_tms,
  output logic             jtag_tdi,
  input  logic             jtag_tdo
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  localparam logic [1:0] OP_RESET     = 2'd0;
  localparam logic [1:0] OP_TMS_SEQ   = 2'd1;
  localparam logic [1:0] OP_SCAN      = 2'd2;
  localparam logic [1:0] OP_SCAN_FLIP = 2'd3;

  // TAP reset: five TMS=1 clocks reach Test-Logic-Reset from any state,
  // the trailing TMS=0 parks the TAP in Run-Test/Idle.
  localparam logic [4:0]  RESET_NLAST = 5'd5;
  localparam logic [31:0] RESET_TMS   = 32'h0000_001F;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       nlast_q, nlast_d;     // N-1
  logic [31:0]      data_q, data_d;
  logic [DIV_W-1:0] half_q, half_d;       // H-1, reload value of the divider
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [31:0]      cap_q, cap_d;
  logic             tck_q, tck_d;
  logic             tms_q, tms_d;
  logic             tdi_q, tdi_d;

  logic             phase_done;
  logic             last_bit;

  assign phase_done = (cnt_q == '0);
  assign last_bit   = (idx_q == nlast_q);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RESET;
      nlast_q <= '0;
      data_q  <= '0;
      half_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      nlast_q <= nlast_d;
      data_q  <= data_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    nlast_d = nlast_q;
    data_d  = data_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cap_d   = cap_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          nlast_d = (cmd_op == OP_RESET) ? RESET_NLAST : cmd_len;
          data_d  = (cmd_op == OP_RESET) ? RESET_TMS : cmd_data;
          half_d  = cfg_half_period;
          cnt_d   = cfg_half_period;
          idx_d   = '0;
          cap_d   = '0;   // keeps bits >= N at zero in the result
          state_d = ST_SHIFT_LO;
        end
      end

      ST_SHIFT_LO: begin
        if (phase_done) begin
          cnt_d   = half_q;
          state_d = ST_SHIFT_HI;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      ST_SHIFT_HI: begin
        if (phase_done) begin
          cap_d[idx_q] = jtag_tdo;
          if (last_bit) begin
            // op[1] set means SCAN or SCAN_FLIP, the only ops with a result
            state_d = op_q[1] ? ST_RESP : ST_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            cnt_d   = half_q;
            state_d = ST_SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // Pins are decoded from the next-state values and registered, so they are
  // glitch-free and line up with the state they belong to. TMS/TDI follow
  // idx_d, which only advances on entry to SHIFT_LO, so they never change in
  // the cycle TCK rises.
  // -------------------------------------------------------------------------
  always_comb begin
    tck_d = 1'b0;
    tms_d = 1'b0;
    tdi_d = 1'b0;
    if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
      tck_d = (state_d == ST_SHIFT_HI);
      case (op_d)
        OP_RESET,
        OP_TMS_SEQ:   tms_d = data_d[idx_d];
        OP_SCAN:      tdi_d = data_d[idx_d];
        OP_SCAN_FLIP: begin
          tdi_d = data_d[idx_d];
          tms_d = (idx_d == nlast_d);
        end
        default: begin
          tms_d = 1'b0;
          tdi_d = 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = ~cmd_ready;
  assign rsp_data  = cap_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jtag_seq_ctrl
//
// Directed bench for jtag_seq_ctrl. Each command is accepted, then every
// system clock of the shift window is sampled #1 after the rising edge and
// compared against the expected TCK phase pattern; TMS/TDI are collected at
// the last cycle of each TCK high phase. TDO can be looped back to TDI.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_jtag_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_half_period;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic        jtag_tck;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_tdo;
  logic        loop_en;

  always #5 clk = ~clk;

  assign jtag_tdo = loop_en & jtag_tdi;

  jtag_seq_ctrl #(.DIV_W(8)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .cfg_half_period (cfg_half_period),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_len         (cmd_len),
    .cmd_data        (cmd_data),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .busy            (busy),
    .jtag_tck        (jtag_tck),
    .jtag_tms        (jtag_tms),
    .jtag_tdi        (jtag_tdi),
    .jtag_tdo        (jtag_tdo)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // per-command observations
  logic [31:0] tms_bits, tdi_bits;
  int tck_rises, tck_err, edge_viol, ready_early, rv_seen, tms_first, tms_cnt;

  // Accept one command (edge T), then sample cycles T+1 .. T+2HN.
  // Returns positioned at cycle T+1+2HN, #1 after its opening edge.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, input logic [7:0] cfg);
    int nb, h, wait_cnt;
    logic ptck, ptms, ptdi;
    nb = (op == 2'd0) ? 6 : int'(len) + 1;
    h  = int'(cfg) + 1;
    tms_bits = '0; tdi_bits = '0;
    tck_rises = 0; tck_err = 0; edge_viol = 0;
    ready_early = 0; rv_seen = 0; tms_first = 0; tms_cnt = 0;

    cmd_op = op; cmd_len = len; cmd_data = data; cfg_half_period = cfg;
    cmd_valid = 1'b1;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("accept_wait", 32'(wait_cnt), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cfg_half_period = 8'hFF;   // must not affect the running command

    ptck = 1'b0; ptms = 1'b0; ptdi = 1'b0;
    for (int k = 1; k <= 2 * h * nb; k++) begin
      if (jtag_tck !== (((k - 1) % (2 * h)) >= h)) tck_err++;
      if (jtag_tck && !ptck) begin
        tck_rises++;
        if (jtag_tms !== ptms || jtag_tdi !== ptdi) edge_viol++;
      end
      if (k % (2 * h) == 0) begin
        tms_bits[k / (2 * h) - 1] = jtag_tms;
        tdi_bits[k / (2 * h) - 1] = jtag_tdi;
      end
      if (jtag_tms) begin
        tms_cnt++;
        if (tms_first == 0) tms_first = k;
      end
      if (cmd_ready) ready_early++;
      if (rsp_valid) rv_seen++;
      ptck = jtag_tck; ptms = jtag_tms; ptdi = jtag_tdi;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, "_pins"}, {29'd0, jtag_tck, jtag_tms, jtag_tdi}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int hold_err;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 5'd0;
    cmd_data = '0; cfg_half_period = 8'd0; rsp_ready = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check_idle_pins("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // RESET, H=1
    run_cmd(2'd0, 5'd0, 32'hFFFF_FFFF, 8'd0);
    check("reset_tms", tms_bits, 32'h0000_001F);
    check("reset_tdi", tdi_bits, 32'h0);
    check("reset_rises", 32'(tck_rises), 32'd6);
    check("reset_tck_phase", 32'(tck_err), 32'd0);
    check("reset_edge", 32'(edge_viol), 32'd0);
    check("reset_ready_early", 32'(ready_early), 32'd0);
    check("reset_ready_end", 32'(cmd_ready), 32'd1);
    check("reset_rv", 32'(rv_seen + int'(rsp_valid)), 32'd0);
    check_idle_pins("reset_end");

    // SCAN N=8 0xA5, H=2, loopback, zero-wait response
    loop_en = 1'b1;
    run_cmd(2'd2, 5'd7, 32'h0000_00A5, 8'd1);
    check("scan8_tdi", tdi_bits, 32'h0000_00A5);
    check("scan8_tms", 32'(tms_cnt), 32'd0);
    check("scan8_tck_phase", 32'(tck_err), 32'd0);
    check("scan8_edge", 32'(edge_viol), 32'd0);
    check_idle_pins("scan8_end");
    check("scan8_rv", 32'(rsp_valid), 32'd1);
    check("scan8_ready_end", 32'(cmd_ready), 32'd0);
    check("scan8_rsp", rsp_data, 32'h0000_00A5);
    @(posedge clk); #1;
    check("scan8_rv_drop", 32'(rsp_valid), 32'd0);
    check("scan8_ready_back", 32'(cmd_ready), 32'd1);

    // SCAN_FLIP N=4 0xF, H=4
    run_cmd(2'd3, 5'd3, 32'h0000_000F, 8'd3);
    check("flip_tms_bits", tms_bits, 32'h0000_0008);
    check("flip_tms_first", 32'(tms_first), 32'd25);
    check("flip_tms_cnt", 32'(tms_cnt), 32'd8);
    check("flip_tdi", tdi_bits, 32'h0000_000F);
    check("flip_rises", 32'(tck_rises), 32'd4);
    check("flip_tck_phase", 32'(tck_err), 32'd0);
    check_idle_pins("flip_end");
    check("flip_rsp", rsp_data, 32'h0000_000F);
    @(posedge clk); #1;

    // SCAN N=32 0xDEADBEEF with back-pressure and a pending command
    rsp_ready = 1'b0;
    run_cmd(2'd2, 5'd31, 32'hDEAD_BEEF, 8'd0);
    check("scan32_tdi", tdi_bits, 32'hDEAD_BEEF);
    check("scan32_edge", 32'(edge_viol), 32'd0);
    cmd_op = 2'd1; cmd_len = 5'd4; cmd_data = 32'h1F; cmd_valid = 1'b1;
    hold_err = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || cmd_ready !== 1'b0
          || jtag_tck !== 1'b0 || jtag_tms !== 1'b0)
        hold_err++;
      @(posedge clk); #1;
    end
    check("scan32_hold", 32'(hold_err), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("scan32_rv_drop", 32'(rsp_valid), 32'd0);
    check("scan32_ready_back", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    @(posedge clk); #1;

    // TMS_SEQ N=5 0x0B, H=3
    loop_en = 1'b0;
    run_cmd(2'd1, 5'd4, 32'h0000_000B, 8'd2);
    check("tms_seq_bits", tms_bits, 32'h0000_000B);
    check("tms_seq_tdi", tdi_bits, 32'h0);
    check("tms_seq_tck_phase", 32'(tck_err), 32'd0);
    check("tms_seq_ready_early", 32'(ready_early), 32'd0);
    check("tms_seq_ready_end", 32'(cmd_ready), 32'd1);
    check("tms_seq_rv", 32'(rv_seen + int'(rsp_valid)), 32'd0);
    check_idle_pins("tms_seq_end");

    // reset during bit 3 of a 16-bit SCAN, H=1
    loop_en = 1'b1;
    cmd_op = 2'd2; cmd_len = 5'd15; cmd_data = 32'h0000_FFFF;
    cfg_half_period = 8'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_pins("abort");
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_rv", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data", rsp_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_rv_later", 32'(rsp_valid), 32'd0);
    run_cmd(2'd2, 5'd7, 32'h0000_003C, 8'd0);
    check("after_abort_rsp", rsp_data, 32'h0000_003C);
    check("after_abort_rv", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
